// File: rtl/half_exp_accum.sv
// Softmax denominator accumulator: sums VEC_LEN FP16 exp() results exactly in
// fixed point (LSB = 2^-24) and returns each vector sum as a rounded FP16 value.
module half_exp_accum #(
  parameter int VEC_LEN = 16,
  parameter int FRAC_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  output logic        out_valid,
  output logic [15:0] sum,
  output logic        ovf,
  output logic        nan,
  output logic        neg_err
);

  localparam int ACC_W = 40 + $clog2(VEC_LEN);
  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int P_W   = $clog2(ACC_W);
  localparam int SUB_P = FRAC_W - 14;

  logic [39:0]      fix_s;
  logic             inf_s, nan_s, neg_s;
  logic [CNT_W-1:0] cnt_r;
  logic             s1_valid_r, s1_last_r, s1_inf_r, s1_nan_r, s1_neg_r;
  logic [39:0]      s1_fix_r;
  logic [ACC_W-1:0] acc_r, fin_r, acc_sum_s;
  logic             st_inf_r, st_nan_r, st_neg_r;
  logic             fin_valid_r, fin_inf_r, fin_nan_r, fin_neg_r;
  logic [P_W-1:0]   msb_s;
  logic [ACC_W-1:0] norm_s;
  logic [9:0]       man_s;
  logic             rnd_s, sub_s;
  logic [7:0]       bexp_s;
  logic             n_valid_r, n_sub_r, n_rnd_r, n_inf_r, n_nan_r, n_neg_r;
  logic [9:0]       n_subv_r, n_man_r;
  logic [7:0]       n_exp_r;
  logic [17:0]      rsum_s;
  logic [15:0]      res_s;
  logic             ovf_s;

  // FP16 to fixed-point conversion and per-element status decode
  always_comb begin
    fix_s = 40'd0;
    neg_s = a[15] && (a[14:0] != 15'd0);
    nan_s = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    inf_s = !a[15] && (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    if (neg_s || (a[14:10] == 5'd31)) begin
      fix_s = 40'd0;
    end else if (a[14:10] == 5'd0) begin
      fix_s = {30'd0, a[9:0]};
    end else begin
      fix_s = {29'd0, 1'b1, a[9:0]} << (a[14:10] - 5'd1);
    end
  end

  // Stage 1: element counter and registered conversion result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_fix_r   <= 40'd0;
      s1_inf_r   <= 1'b0;
      s1_nan_r   <= 1'b0;
      s1_neg_r   <= 1'b0;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_fix_r  <= fix_s;
        s1_inf_r  <= inf_s;
        s1_nan_r  <= nan_s;
        s1_neg_r  <= neg_s;
        s1_last_r <= (cnt_r == CNT_W'(VEC_LEN - 1));
        cnt_r     <= (cnt_r == CNT_W'(VEC_LEN - 1)) ? '0 : cnt_r + CNT_W'(1);
      end
    end
  end

  assign acc_sum_s = acc_r + ACC_W'(s1_fix_r);

  // Stage 2: exact accumulation; last element hands the total and flags onward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      fin_r       <= '0;
      fin_valid_r <= 1'b0;
      st_inf_r    <= 1'b0;
      st_nan_r    <= 1'b0;
      st_neg_r    <= 1'b0;
      fin_inf_r   <= 1'b0;
      fin_nan_r   <= 1'b0;
      fin_neg_r   <= 1'b0;
    end else begin
      fin_valid_r <= 1'b0;
      if (s1_valid_r && s1_last_r) begin
        fin_r       <= acc_sum_s;
        acc_r       <= '0;
        fin_valid_r <= 1'b1;
        fin_inf_r   <= st_inf_r | s1_inf_r;
        fin_nan_r   <= st_nan_r | s1_nan_r;
        fin_neg_r   <= st_neg_r | s1_neg_r;
        st_inf_r    <= 1'b0;
        st_nan_r    <= 1'b0;
        st_neg_r    <= 1'b0;
      end else if (s1_valid_r) begin
        acc_r    <= acc_sum_s;
        st_inf_r <= st_inf_r | s1_inf_r;
        st_nan_r <= st_nan_r | s1_nan_r;
        st_neg_r <= st_neg_r | s1_neg_r;
      end
    end
  end

  // Leading-one detect and normalisation; a zero total falls into the subnormal path
  always_comb begin
    msb_s = '0;
    for (int i = 0; i < ACC_W; i++) begin
      msb_s = fin_r[i] ? P_W'(i) : msb_s;
    end
    norm_s = fin_r << (P_W'(ACC_W - 1) - msb_s);
    man_s  = norm_s[ACC_W-2 -: 10];
    rnd_s  = norm_s[ACC_W-12] & ((|norm_s[ACC_W-13:0]) | man_s[0]);
    bexp_s = 8'(msb_s) - 8'(FRAC_W - 15);
    sub_s  = (msb_s < P_W'(SUB_P)) || !norm_s[ACC_W-1];
  end

  // Stage 3a: register normalised fields and round decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_valid_r <= 1'b0;
      n_sub_r   <= 1'b0;
      n_subv_r  <= 10'd0;
      n_exp_r   <= 8'd0;
      n_man_r   <= 10'd0;
      n_rnd_r   <= 1'b0;
      n_inf_r   <= 1'b0;
      n_nan_r   <= 1'b0;
      n_neg_r   <= 1'b0;
    end else begin
      n_valid_r <= fin_valid_r;
      if (fin_valid_r) begin
        n_sub_r  <= sub_s;
        n_subv_r <= fin_r[9:0];
        n_exp_r  <= bexp_s;
        n_man_r  <= man_s;
        n_rnd_r  <= rnd_s;
        n_inf_r  <= fin_inf_r;
        n_nan_r  <= fin_nan_r;
        n_neg_r  <= fin_neg_r;
      end
    end
  end

  // Mantissa carry ripples straight into the exponent field
  assign rsum_s = {n_exp_r, n_man_r} + 18'(n_rnd_r);

  // Result selection: NaN beats inf beats the rounded value
  always_comb begin
    res_s = 16'h0000;
    ovf_s = n_inf_r;
    if (n_nan_r) begin
      res_s = 16'h7E00;
    end else if (n_inf_r) begin
      res_s = 16'h7C00;
    end else if (n_sub_r) begin
      res_s = {6'd0, n_subv_r};
    end else if (rsum_s[17:10] >= 8'd31) begin
      res_s = 16'h7C00;
      ovf_s = 1'b1;
    end else begin
      res_s = {1'b0, rsum_s[14:0]};
    end
  end

  // Stage 3b: registered outputs, held between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= 16'h0000;
      ovf       <= 1'b0;
      nan       <= 1'b0;
      neg_err   <= 1'b0;
    end else begin
      out_valid <= n_valid_r;
      if (n_valid_r) begin
        sum     <= res_s;
        ovf     <= ovf_s;
        nan     <= n_nan_r;
        neg_err <= n_neg_r;
      end
    end
  end

endmodule

// File: tb/tb_half_exp_accum.sv
// Bench for half_exp_accum: a VEC_LEN=16 and a VEC_LEN=4 instance, table-driven
// vectors with a scoreboard of expected sums, flags and output cycle.
module tb_half_exp_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv16, iv4;
  logic [15:0] a16, a4;
  logic        ov16, ov4, of16, of4, na16, na4, ng16, ng4;
  logic [15:0] s16, s4;

  always #5 clk = ~clk;

  half_exp_accum #(.VEC_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .out_valid(ov16),
    .sum(s16), .ovf(of16), .nan(na16), .neg_err(ng16)
  );

  half_exp_accum #(.VEC_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .out_valid(ov4),
    .sum(s4), .ovf(of4), .nan(na4), .neg_err(ng4)
  );

  typedef struct {
    string       name;
    logic [15:0] sum;
    logic        ovf, nan, neg;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] el[4];
    int          gap_at;
    int          gap_len;
    logic [15:0] sum;
    logic        ovf, nan, neg;
  } vec_t;

  exp_t q16[$], q4[$];
  vec_t tbl[7];
  int   checks = 0, errors = 0, cyc = 0, pulses4 = 0, pulses16 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input logic [15:0] e0, e1, e2, e3,
                         input int gat, input int glen, input logic [15:0] s,
                         input logic o, input logic n, input logic g);
    tbl[i].name = nm;
    tbl[i].el[0] = e0; tbl[i].el[1] = e1; tbl[i].el[2] = e2; tbl[i].el[3] = e3;
    tbl[i].gap_at = gat; tbl[i].gap_len = glen;
    tbl[i].sum = s; tbl[i].ovf = o; tbl[i].nan = n; tbl[i].neg = g;
  endtask

  task automatic drive4(input logic v, input logic [15:0] x);
    @(negedge clk);
    iv4 = v;
    a4  = x;
  endtask

  task automatic push4(input string nm, input logic [15:0] s, input logic o, input logic n, input logic g);
    exp_t e;
    e.name = nm; e.sum = s; e.ovf = o; e.nan = n; e.neg = g;
    e.cyc = cyc + 4;
    q4.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid4"}, ov4, 0);
    check({tag, " sum4"}, s4, 16'h0000);
    check({tag, " flags4"}, {of4, na4, ng4}, 3'b000);
    check({tag, " out_valid16"}, ov16, 0);
    check({tag, " sum16"}, s16, 16'h0000);
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q16.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain pending", q4.size() + q16.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  // Scoreboard: compare every output pulse against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov4) begin
      pulses4++;
      if (q4.size() == 0) begin
        check("dut4 unexpected pulse", ov4, 0);
      end else begin
        e = q4.pop_front();
        check({e.name, " sum"}, s4, e.sum);
        check({e.name, " ovf"}, of4, e.ovf);
        check({e.name, " nan"}, na4, e.nan);
        check({e.name, " neg_err"}, ng4, e.neg);
        check({e.name, " cycle"}, cyc, e.cyc);
      end
    end
    if (!rst && ov16) begin
      pulses16++;
      if (q16.size() == 0) begin
        check("dut16 unexpected pulse", ov16, 0);
      end else begin
        e = q16.pop_front();
        check({e.name, " sum"}, s16, e.sum);
        check({e.name, " flags"}, {of16, na16, ng16}, {e.ovf, e.nan, e.neg});
        check({e.name, " cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1; iv16 = 1'b0; iv4 = 1'b0; a16 = 16'h0000; a4 = 16'h0000;

    set_vec(0, "mixed_6p5", 16'h3C00, 16'h4000, 16'h4200, 16'h3800, 2, 2, 16'h4680, 1'b0, 1'b0, 1'b0);
    set_vec(1, "subnorm_4", 16'h0001, 16'h0001, 16'h0001, 16'h0001, -1, 0, 16'h0004, 1'b0, 1'b0, 1'b0);
    set_vec(2, "tie_even", 16'h6400, 16'h3800, 16'h0000, 16'h0000, -1, 0, 16'h6400, 1'b0, 1'b0, 1'b0);
    set_vec(3, "round_up", 16'h6400, 16'h3E00, 16'h0000, 16'h0000, -1, 0, 16'h6402, 1'b0, 1'b0, 1'b0);
    set_vec(4, "overflow", 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, -1, 0, 16'h7C00, 1'b1, 1'b0, 1'b0);
    set_vec(5, "nan_inf", 16'h3C00, 16'h7E00, 16'h7C00, 16'h3C00, -1, 0, 16'h7E00, 1'b1, 1'b1, 1'b0);
    set_vec(6, "negative", 16'hC000, 16'h3C00, 16'h8000, 16'h3C00, -1, 0, 16'h4000, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check_reset_outputs("initial reset");
    rst = 1'b0;

    // Sixteen 1.0 back to back on the VEC_LEN=16 instance
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      iv16 = 1'b1;
      a16  = 16'h3C00;
    end
    e.name = "ones_x16"; e.sum = 16'h4C00; e.ovf = 1'b0; e.nan = 1'b0; e.neg = 1'b0;
    e.cyc = cyc + 4;
    q16.push_back(e);
    @(negedge clk);
    iv16 = 1'b0;

    // Table vectors on the VEC_LEN=4 instance, back to back apart from listed gaps
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == tbl[v].gap_at) repeat (tbl[v].gap_len) drive4(1'b0, 16'h0000);
        drive4(1'b1, tbl[v].el[k]);
        if (k == 3) push4(tbl[v].name, tbl[v].sum, tbl[v].ovf, tbl[v].nan, tbl[v].neg);
      end
    end
    drive4(1'b0, 16'h0000);
    drain();

    // Reset in the middle of a vector discards the partial sum
    drive4(1'b1, 16'h3C00);
    drive4(1'b1, 16'h3C00);
    @(negedge clk);
    iv4 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-vector reset");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive4(1'b1, 16'h3C00);
    end
    push4("after_reset", 16'h4400, 1'b0, 1'b0, 1'b0);
    drive4(1'b0, 16'h0000);
    drain();

    check("dut4 pulse count", pulses4, 8);
    check("dut16 pulse count", pulses16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
